// File: rtl/mul_prog_q.sv
// Pipelined digit-serial signed Q1.(W-1) multiplier with per-item output precision and saturation.
// Build option: define MUL_PROG_ROUND_EN for round-half-up; otherwise the result is truncated.
module mul_prog_q #(
  parameter  int W       = 16,
  parameter  int DIGIT_W = 4,
  localparam int N       = W / DIGIT_W,
  localparam int PW      = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  input  logic [PW-1:0] prec_sel,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic          out_sat
);

  if (W % DIGIT_W != 0) begin : g_bad_digit
    $error("mul_prog_q: W must be a multiple of DIGIT_W");
  end

  logic            vld_q [N];
  logic [2*W-1:0]  acc_q [N];
  logic [W-1:0]    a_q   [N];
  logic [W-1:0]    b_q   [N];
  logic [PW-1:0]   p_q   [N];

  logic            en;
  assign en       = !out_valid | out_ready;
  assign in_ready = en;

  // Partial product a * d << shift; only the top digit of b carries sign.
  function automatic logic [2*W-1:0] pp(input logic [W-1:0] x, input logic [DIGIT_W-1:0] d,
                                        input logic top, input int k);
    logic [2*W-1:0] xe;
    logic [2*W-1:0] de;
    xe = {{W{x[W-1]}}, x};
    de = {{(2*W-DIGIT_W){top & d[DIGIT_W-1]}}, d};
    return (xe * de) << (k * DIGIT_W);
  endfunction

  int              pd;
  int              lsb;
  logic            msb;
  logic [W+2:0]    vx;
  logic [W+2:0]    inc;
  logic [W+2:0]    r;
  logic [W-1:0]    mask;
  logic [W-1:0]    sat_val;
  logic [W-1:0]    res;
  logic            ovf;

  always_comb begin
    pd      = (int'(p_q[N-1]) >= N) ? N : int'(p_q[N-1]) + 1;
    lsb     = W - pd * DIGIT_W;
    mask    = {W{1'b1}} << lsb;
    msb     = acc_q[N-1][2*W-1];
    // vx = sign-extended {sign, Q1.(W-1) window, guard bit}; guard is the round bit at full precision
    vx      = {msb, acc_q[N-1][2*W-1:W-2]};
    inc     = '0;
`ifdef MUL_PROG_ROUND_EN
    inc     = (W+3)'(1) << lsb;
`endif
    r       = vx + inc;
    ovf     = (msb != acc_q[N-1][2*W-2]) | (r[W+2] != r[W+1]) | (r[W+1] != r[W]);
    sat_val = msb ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    res     = (ovf ? sat_val : r[W:1]) & mask;
  end

  logic unused_bits;
  assign unused_bits = ^{acc_q[N-1][W-3:0], r[0], a_q[N-1], b_q[N-1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin
        vld_q[k] <= 1'b0;
        acc_q[k] <= '0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        p_q[k]   <= '0;
      end
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (en) begin
      vld_q[0] <= in_valid;
      a_q[0]   <= a;
      b_q[0]   <= b >> DIGIT_W;
      p_q[0]   <= prec_sel;
      acc_q[0] <= pp(a, b[DIGIT_W-1:0], N == 1, 0);
      for (int k = 1; k < N; k++) begin
        vld_q[k] <= vld_q[k-1];
        a_q[k]   <= a_q[k-1];
        b_q[k]   <= b_q[k-1] >> DIGIT_W;
        p_q[k]   <= p_q[k-1];
        acc_q[k] <= acc_q[k-1] + pp(a_q[k-1], b_q[k-1][DIGIT_W-1:0], k == N-1, k);
      end
      out_valid <= vld_q[N-1];
      out_data  <= vld_q[N-1] ? res : '0;
      out_sat   <= vld_q[N-1] & ovf;
    end
  end

endmodule
